ring_meas_sched: RTL and testbench
==================================

// Module: ring_meas_sched
// PURPOSE
//  Measurement scheduler for the ring-oscillator counter/scan datapath. It steps the 6-bit
//  grey-coded channel select through the 10 ring/ring-pair channels, either automatically or
//  from a manual code. For each channel it issues clear, count-gate and latch controls to the
//  frequency counters, then holds the result for a display dwell. o_sel feeds the scan mux select.
// PARAMETERS
//  P_SETTLE  16      cycles between o_clr and o_gate (ring start-up settle), >=1
//  P_GATE    10_000  cycles o_gate is held high (count window), >=1
//  P_DWELL   60_000  cycles after o_latch before the next channel (display time), >=1
//  All values < 2^20; one shared 20-bit down-counter times every phase.
// PORTS
//  i_clk      in   1  clock, all logic on posedge
//  i_rst_n    in   1  reset, synchronous, active-low
//  i_en       in   1  1 = run sequence; 0 = abort to IDLE
//  i_auto     in   1  1 = auto-step channels; 0 = manual select
//  i_hold     in   1  1 = re-measure current channel instead of advancing (auto mode)
//  i_man_sel  in   6  manual select code, sampled only at channel boundaries
//  o_sel      out  6  channel select to scan mux (registered)
//  o_idx      out  4  channel index 0..9 matching o_sel
//  o_clr      out  1  1-cycle pulse: clear ring counters
//  o_gate     out  1  level: counters enabled
//  o_latch    out  1  1-cycle pulse: capture counts into scan inputs
//  o_busy     out  1  1 in every state except IDLE
//  o_bad      out  1  1-cycle pulse: invalid i_man_sel rejected
// BEHAVIOUR
//  Channel table idx->sel: 0:000001 1:000011 2:000010 3:000110 4:000100 5:001100
//   6:001000 7:011000 8:010000 9:110000. Any other code is invalid.
//  Reset (i_rst_n=0 at an edge): state IDLE, idx 0, o_sel 000001, o_clr/o_gate/o_latch/o_busy/o_bad 0,
//   timer 0. Reset mid-phase overrides everything; o_gate drops at that edge.
//  FSM (registered outputs, decoded from next state):
//   IDLE   : if i_en -> CLEAR. In manual mode, i_man_sel is sampled on this edge.
//   CLEAR  : 1 cycle, o_clr=1 -> SETTLE
//   SETTLE : P_SETTLE cycles -> GATE
//   GATE   : P_GATE cycles, o_gate=1 -> LATCH
//   LATCH  : 1 cycle, o_latch=1 -> DWELL
//   DWELL  : P_DWELL cycles -> ADVANCE
//   ADVANCE: 1 cycle; selects the next channel (below) -> CLEAR, or IDLE if !i_en
//  Per-channel period = P_SETTLE+P_GATE+P_DWELL+3 cycles. o_sel changes only on the edge leaving
//   ADVANCE or IDLE, so it is stable from o_clr through the end of DWELL.
//  Next channel: auto & !i_hold: idx = (idx==9) ? 0 : idx+1 (wrap). auto & i_hold: idx unchanged.
//   manual: valid i_man_sel -> o_sel=i_man_sel, idx=table index. Invalid -> o_sel/idx unchanged,
//   o_bad pulses 1 cycle. i_hold is ignored in manual mode.
//  i_auto/i_hold/i_man_sel are sampled only at ADVANCE/IDLE exit; mid-phase changes have no effect.
//  i_en=0 in any non-IDLE state: IDLE on the next edge. o_gate falls at that edge, no o_latch is
//   issued, and o_sel/idx are kept. Re-enable restarts at CLEAR on the same channel.
//  Switching auto->manual takes effect at the next boundary; manual->auto continues from current idx.
// CONFIGURATION
//  RING_MEAS_SCHED_STAT_EN defined: adds port o_sweeps out 8, reset 0. It increments on each auto
//   wrap 9->0 (the ADVANCE edge) and wraps modulo 256. Holds, manual steps and aborts do not count.
//  Undefined: no o_sweeps port and no counter logic; all other behaviour is identical.
// TESTING (bench params P_SETTLE=2, P_GATE=5, P_DWELL=3 -> period 13)
//  Reset, i_en=1, i_auto=1 -> o_clr 1 cycle, o_gate exactly 5 cycles starting 3 cycles after o_clr,
//   o_latch 1 cycle after gate, next o_clr 13 cycles after the first, o_sel 000001->000011.
//  Auto run for 10 channels -> o_sel visits the table in order, then returns to 000001, idx 9->0;
//   with STAT_EN, o_sweeps 0->1 at the wrap.
//  i_hold=1 at ADVANCE on idx 4 -> o_sel stays 000100 for a second full period; hold mid-GATE is ignored.
//  Manual, i_man_sel=011000 -> o_sel=011000, idx=7; then i_man_sel=000101 -> o_bad pulse, o_sel stays.
//  i_en=0 during the 3rd gate cycle -> o_gate low next edge, no o_latch, o_busy=0, o_sel unchanged.
//   i_en=1 -> CLEAR on same channel.
//  i_rst_n=0 during DWELL on idx 6 -> next edge idx 0, o_sel 000001, all pulses/levels 0, o_busy 0.

Source files
------------

// File: rtl/ring_meas_sched.sv
// Ring-oscillator measurement scheduler: steps the grey-coded channel select and sequences clear/gate/latch/dwell.
// Optional sweep counter port o_sweeps is enabled by defining RING_MEAS_SCHED_STAT_EN.
`timescale 1ns/1ps

module ring_meas_sched #(
    parameter int unsigned P_SETTLE = 16,
    parameter int unsigned P_GATE   = 10_000,
    parameter int unsigned P_DWELL  = 60_000
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_en,
    input  logic       i_auto,
    input  logic       i_hold,
    input  logic [5:0] i_man_sel,
    output logic [5:0] o_sel,
    output logic [3:0] o_idx,
    output logic       o_clr,
    output logic       o_gate,
    output logic       o_latch,
    output logic       o_busy,
    output logic       o_bad
`ifdef RING_MEAS_SCHED_STAT_EN
    ,
    output logic [7:0] o_sweeps
`endif
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_SETTLE,
        S_GATE,
        S_LATCH,
        S_DWELL,
        S_ADVANCE
    } state_t;

    localparam logic [19:0] L_SETTLE = 20'(P_SETTLE - 1);
    localparam logic [19:0] L_GATE   = 20'(P_GATE - 1);
    localparam logic [19:0] L_DWELL  = 20'(P_DWELL - 1);

    state_t      state_q, state_d;
    logic [19:0] timer_q, timer_d;
    logic [3:0]  idx_q, idx_d;
    logic [5:0]  sel_q;
    logic        clr_q, gate_q, latch_q, busy_q, bad_q, bad_d;
    logic        step;
    logic        enter;
    logic [4:0]  man_dec;

    // Channel index -> grey-coded ring select.
    function automatic logic [5:0] idx_to_sel(input logic [3:0] idx);
        logic [5:0] s;
        s = 6'b000001;
        case (idx)
            4'd0:    s = 6'b000001;
            4'd1:    s = 6'b000011;
            4'd2:    s = 6'b000010;
            4'd3:    s = 6'b000110;
            4'd4:    s = 6'b000100;
            4'd5:    s = 6'b001100;
            4'd6:    s = 6'b001000;
            4'd7:    s = 6'b011000;
            4'd8:    s = 6'b010000;
            4'd9:    s = 6'b110000;
            default: s = 6'b000001;
        endcase
        return s;
    endfunction

    // Returns {valid, idx}; valid=0 for any code outside the channel table.
    function automatic logic [4:0] sel_decode(input logic [5:0] code);
        logic [4:0] r;
        r = '0;
        case (code)
            6'b000001: r = {1'b1, 4'd0};
            6'b000011: r = {1'b1, 4'd1};
            6'b000010: r = {1'b1, 4'd2};
            6'b000110: r = {1'b1, 4'd3};
            6'b000100: r = {1'b1, 4'd4};
            6'b001100: r = {1'b1, 4'd5};
            6'b001000: r = {1'b1, 4'd6};
            6'b011000: r = {1'b1, 4'd7};
            6'b010000: r = {1'b1, 4'd8};
            6'b110000: r = {1'b1, 4'd9};
            default:   r = '0;
        endcase
        return r;
    endfunction

    assign man_dec = sel_decode(i_man_sel);
    assign step    = (state_q == S_ADVANCE) && i_en;
    assign enter   = (state_q == S_IDLE) && i_en;

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        idx_d   = idx_q;
        bad_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (i_en) begin
                    state_d = S_CLEAR;
                end
            end
            S_CLEAR: begin
                state_d = S_SETTLE;
                timer_d = L_SETTLE;
            end
            S_SETTLE: begin
                if (timer_q == '0) begin
                    state_d = S_GATE;
                    timer_d = L_GATE;
                end else begin
                    timer_d = timer_q - 20'd1;
                end
            end
            S_GATE: begin
                if (timer_q == '0) begin
                    state_d = S_LATCH;
                    timer_d = '0;
                end else begin
                    timer_d = timer_q - 20'd1;
                end
            end
            S_LATCH: begin
                state_d = S_DWELL;
                timer_d = L_DWELL;
            end
            S_DWELL: begin
                if (timer_q == '0) begin
                    state_d = S_ADVANCE;
                    timer_d = '0;
                end else begin
                    timer_d = timer_q - 20'd1;
                end
            end
            S_ADVANCE: begin
                state_d = S_CLEAR;
            end
            default: begin
                state_d = S_IDLE;
                timer_d = '0;
            end
        endcase

        // Abort wins over any phase transition; channel is left untouched.
        if (state_q != S_IDLE && !i_en) begin
            state_d = S_IDLE;
            timer_d = '0;
        end

        // Channel selection only at a boundary; auto restart from IDLE keeps the current channel.
        if (step || (enter && !i_auto)) begin
            if (i_auto) begin
                if (!i_hold) begin
                    idx_d = (idx_q == 4'd9) ? 4'd0 : idx_q + 4'd1;
                end
            end else if (man_dec[4]) begin
                idx_d = man_dec[3:0];
            end else begin
                bad_d = 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q <= S_IDLE;
            timer_q <= '0;
            idx_q   <= '0;
            sel_q   <= 6'b000001;
            clr_q   <= 1'b0;
            gate_q  <= 1'b0;
            latch_q <= 1'b0;
            busy_q  <= 1'b0;
            bad_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            idx_q   <= idx_d;
            sel_q   <= idx_to_sel(idx_d);
            clr_q   <= (state_d == S_CLEAR);
            gate_q  <= (state_d == S_GATE);
            latch_q <= (state_d == S_LATCH);
            busy_q  <= (state_d != S_IDLE);
            bad_q   <= bad_d;
        end
    end

    assign o_sel   = sel_q;
    assign o_idx   = idx_q;
    assign o_clr   = clr_q;
    assign o_gate  = gate_q;
    assign o_latch = latch_q;
    assign o_busy  = busy_q;
    assign o_bad   = bad_q;

`ifdef RING_MEAS_SCHED_STAT_EN
    logic [7:0] sweeps_q;
    logic       wrap;

    assign wrap = step && i_auto && !i_hold && (idx_q == 4'd9);

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            sweeps_q <= '0;
        end else if (wrap) begin
            sweeps_q <= sweeps_q + 8'd1;
        end
    end

    assign o_sweeps = sweeps_q;
`endif

endmodule

// File: tb/tb_ring_meas_sched.sv
// Self-checking bench for ring_meas_sched with short phase lengths (period 13 cycles).
`timescale 1ns/1ps

module tb_ring_meas_sched;

    localparam int unsigned PS  = 2;
    localparam int unsigned PG  = 5;
    localparam int unsigned PD  = 3;
    localparam int          PER = 13;

    logic       clk = 1'b0;
    logic       rst_n, en, auto_m, hold;
    logic [5:0] man_sel;
    logic [5:0] o_sel;
    logic [3:0] o_idx;
    logic       o_clr, o_gate, o_latch, o_busy, o_bad;
`ifdef RING_MEAS_SCHED_STAT_EN
    logic [7:0] o_sweeps;
`endif

    always #5 clk = ~clk;

    ring_meas_sched #(.P_SETTLE(PS), .P_GATE(PG), .P_DWELL(PD)) dut (
        .i_clk     (clk),
        .i_rst_n   (rst_n),
        .i_en      (en),
        .i_auto    (auto_m),
        .i_hold    (hold),
        .i_man_sel (man_sel),
        .o_sel     (o_sel),
        .o_idx     (o_idx),
        .o_clr     (o_clr),
        .o_gate    (o_gate),
        .o_latch   (o_latch),
        .o_busy    (o_busy),
`ifdef RING_MEAS_SCHED_STAT_EN
        .o_sweeps  (o_sweeps),
`endif
        .o_bad     (o_bad)
    );

    typedef struct {
        logic [5:0] sel;
        logic [3:0] idx;
    } exp_t;

    typedef struct {
        logic [5:0] man;
        logic       hold;
        logic [5:0] sel;
        logic [3:0] idx;
        logic       bad;
    } vec_t;

    exp_t       exp_q[$];
    int         n_cmp = 0;
    int         n_mis = 0;
    logic [5:0] chan_tab[10] = '{6'b000001, 6'b000011, 6'b000010, 6'b000110, 6'b000100,
                                 6'b001100, 6'b001000, 6'b011000, 6'b010000, 6'b110000};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push(input logic [5:0] sel, input logic [3:0] idx);
        exp_t e;
        e.sel = sel;
        e.idx = idx;
        exp_q.push_back(e);
    endtask

    // One clock; every o_clr pops the expected channel for the measurement just starting.
    task automatic tick;
        exp_t e;
        @(posedge clk);
        #1;
        if (o_clr) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_mis++;
                $display("FAIL sb_unexpected_clr: got clr with sel %b, expected no clr", o_sel);
            end else begin
                e = exp_q.pop_front();
                chk("sb_sel", 32'(o_sel), 32'(e.sel));
                chk("sb_idx", 32'(o_idx), 32'(e.idx));
            end
        end
    endtask

    // Bounded wait for the next o_clr; n=0 on timeout.
    task automatic run_to_clr(input int limit, output int n, output int bads);
        bit found;
        found = 1'b0;
        n     = 0;
        bads  = 0;
        for (int i = 1; i <= limit && !found; i++) begin
            tick();
            if (o_bad) bads++;
            if (o_clr) begin
                n     = i;
                found = 1'b1;
            end
        end
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_sel"},   32'(o_sel), 32'h01);
        chk({tag, "_idx"},   32'(o_idx), 32'h0);
        chk({tag, "_clr"},   32'(o_clr), 32'h0);
        chk({tag, "_gate"},  32'(o_gate), 32'h0);
        chk({tag, "_latch"}, 32'(o_latch), 32'h0);
        chk({tag, "_busy"},  32'(o_busy), 32'h0);
        chk({tag, "_bad"},   32'(o_bad), 32'h0);
`ifdef RING_MEAS_SCHED_STAT_EN
        chk({tag, "_sweeps"}, 32'(o_sweeps), 32'h0);
`endif
    endtask

    initial begin
        vec_t vt[14];
        int   n, b;
        int   first, second, gstart, gcount, latch_at, sel_chg, bad_cnt;

        vt[0]  = '{6'b011000, 1'b0, 6'b011000, 4'd7, 1'b0};
        vt[1]  = '{6'b000101, 1'b0, 6'b011000, 4'd7, 1'b1};
        vt[2]  = '{6'b110000, 1'b1, 6'b110000, 4'd9, 1'b0};
        vt[3]  = '{6'b000000, 1'b0, 6'b110000, 4'd9, 1'b1};
        vt[4]  = '{6'b000100, 1'b0, 6'b000100, 4'd4, 1'b0};
        vt[5]  = '{6'b001100, 1'b1, 6'b001100, 4'd5, 1'b0};
        vt[6]  = '{6'b000010, 1'b0, 6'b000010, 4'd2, 1'b0};
        vt[7]  = '{6'b111111, 1'b0, 6'b000010, 4'd2, 1'b1};
        vt[8]  = '{6'b000001, 1'b0, 6'b000001, 4'd0, 1'b0};
        vt[9]  = '{6'b010000, 1'b0, 6'b010000, 4'd8, 1'b0};
        vt[10] = '{6'b000110, 1'b0, 6'b000110, 4'd3, 1'b0};
        vt[11] = '{6'b001000, 1'b0, 6'b001000, 4'd6, 1'b0};
        vt[12] = '{6'b000011, 1'b0, 6'b000011, 4'd1, 1'b0};
        vt[13] = '{6'b100000, 1'b0, 6'b000011, 4'd1, 1'b1};

        // Reset and idle.
        rst_n   = 1'b0;
        en      = 1'b0;
        auto_m  = 1'b1;
        hold    = 1'b0;
        man_sel = 6'b000001;
        repeat (3) tick();
        chk_reset_state("rst");
        rst_n = 1'b1;
        repeat (2) tick();
        chk("idle_busy", 32'(o_busy), 32'h0);
        chk("idle_clr",  32'(o_clr), 32'h0);

        // First auto period: pulse timing and select stability.
        en = 1'b1;
        push(6'b000001, 4'd0);
        push(6'b000011, 4'd1);
        first = -1; second = -1; gstart = -1; gcount = 0; latch_at = -1; sel_chg = 0;
        for (int k = 1; k <= 40 && second < 0; k++) begin
            tick();
            if (o_clr) begin
                if (first < 0) first = k;
                else second = k;
            end
            if (second < 0) begin
                if (o_gate) begin
                    if (gstart < 0) gstart = k;
                    gcount++;
                end
                if (o_latch) latch_at = k;
                if (first >= 0 && o_sel != 6'b000001) sel_chg++;
            end
        end
        chk("first_clr_cycle", 32'(first), 32'd1);
        chk("gate_start_ofs",  32'(gstart - first), 32'd3);
        chk("gate_len",        32'(gcount), 32'(PG));
        chk("latch_ofs",       32'(latch_at - first), 32'd8);
        chk("clr_period",      32'(second - first), 32'(PER));
        chk("sel_stable",      32'(sel_chg), 32'd0);
        chk("run_busy",        32'(o_busy), 32'h1);

        // Remaining auto channels and wrap back to channel 0.
        for (int c = 2; c <= 10; c++) push(chan_tab[c % 10], 4'(c % 10));
        for (int c = 2; c <= 10; c++) begin
            run_to_clr(PER + 4, n, b);
            chk("auto_period", 32'(n), 32'(PER));
        end
        chk("wrap_idx", 32'(o_idx), 32'h0);
`ifdef RING_MEAS_SCHED_STAT_EN
        chk("wrap_sweeps", 32'(o_sweeps), 32'h1);
`endif

        // Manual table; the mode switch mid-period only takes effect at the boundary.
        auto_m = 1'b0;
        for (int i = 0; i < 14; i++) begin
            man_sel = vt[i].man;
            hold    = vt[i].hold;
            push(vt[i].sel, vt[i].idx);
            run_to_clr(PER + 4, n, b);
            chk("man_period", 32'(n), 32'(PER));
            chk("man_bad",    32'(b), 32'(vt[i].bad));
        end

        // Back to auto from idx 1; hold pulsed mid-gate must be ignored.
        auto_m = 1'b1;
        hold   = 1'b0;
        push(6'b000010, 4'd2);
        run_to_clr(PER + 4, n, b);
        chk("m2a_period", 32'(n), 32'(PER));
        push(6'b000110, 4'd3);
        run_to_clr(PER + 4, n, b);
        repeat (4) tick();
        chk("hold_in_gate", 32'(o_gate), 32'h1);
        hold = 1'b1;
        tick();
        hold = 1'b0;
        push(6'b000100, 4'd4);
        run_to_clr(PER + 4, n, b);
        chk("midgate_hold_period", 32'(n), 32'(PER - 5));

        // Hold across the boundary: channel 4 measured twice.
        hold = 1'b1;
        push(6'b000100, 4'd4);
        run_to_clr(PER + 4, n, b);
        chk("hold_period", 32'(n), 32'(PER));
        hold = 1'b0;
        push(6'b001100, 4'd5);
        run_to_clr(PER + 4, n, b);
        chk("post_hold_period", 32'(n), 32'(PER));
`ifdef RING_MEAS_SCHED_STAT_EN
        chk("hold_sweeps", 32'(o_sweeps), 32'h1);
`endif

        // Abort in the 3rd gate cycle of channel 5.
        repeat (5) tick();
        chk("gate_3rd", 32'(o_gate), 32'h1);
        en = 1'b0;
        tick();
        chk("abort_gate",  32'(o_gate), 32'h0);
        chk("abort_latch", 32'(o_latch), 32'h0);
        chk("abort_busy",  32'(o_busy), 32'h0);
        chk("abort_sel",   32'(o_sel), 32'(6'b001100));
        chk("abort_idx",   32'(o_idx), 32'h5);
        bad_cnt = 0;
        repeat (5) begin
            tick();
            if (o_latch || o_clr || o_gate || o_busy) bad_cnt++;
        end
        chk("abort_quiet", 32'(bad_cnt), 32'h0);
        en = 1'b1;
        push(6'b001100, 4'd5);
        tick();
        chk("restart_clr", 32'(o_clr), 32'h1);
        push(6'b001000, 4'd6);
        run_to_clr(PER + 4, n, b);
        chk("restart_period", 32'(n), 32'(PER));

        // Reset during dwell of channel 6.
        repeat (10) tick();
        chk("dwell_gate", 32'(o_gate), 32'h0);
        chk("dwell_busy", 32'(o_busy), 32'h1);
        rst_n = 1'b0;
        tick();
        chk_reset_state("midrst");
        tick();
        rst_n = 1'b1;
        push(6'b000001, 4'd0);
        tick();
        chk("post_reset_clr", 32'(o_clr), 32'h1);
        chk("sb_drained", 32'(exp_q.size()), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
